mips_mem_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency unified memory between the MIPS fetch stage (instruction port) and the memory stage (data port).
- Sits between the `mips` core's instr/pc and readData/aluOut/writeData/memWrite interfaces and the memory model.
- Serialises accesses, prioritises data with an anti-starvation rule, and returns per-port ready pulses. The core stalls a stage while its req is high and its ready is low.

---
 rtl/mips_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency memory between the MIPS
// fetch (instruction) port and the memory-stage (data) port. Data has priority,
// except that a long run of data grants with a fetch pending forces a fetch.
// Every output is a register.

module mips_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  // Instruction (fetch) port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  // Data (memory stage) port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  // Memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CntW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic                gnt_data_q, gnt_data_d;  // 1: current access belongs to data port
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CntW-1:0]     wait_q, wait_d;
  logic [StarveW-1:0]  starve_q, starve_d;

  logic                cand_i, cand_d, force_i, pick_d, arb_en;

  logic                issue_n, capture;
  logic                mem_en_d, mem_we_d, i_ready_d, d_ready_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d, i_rdata_d, d_rdata_d;

  // Arbitration: in RESP the port being answered is still holding its req, so it is masked.
  always_comb begin
    cand_i  = i_req && !(state_q == StResp && !gnt_data_q);
    cand_d  = d_req && !(state_q == StResp && gnt_data_q);
    force_i = (starve_q == StarveW'(STARVE_MAX)) && cand_i;
    pick_d  = cand_d && !force_i;
    arb_en  = (state_q == StIdle || state_q == StResp) && (cand_i || cand_d);
  end

  // Next-state logic: FSM, transaction latch, wait counter and starvation counter.
  always_comb begin
    state_d    = state_q;
    gnt_data_d = gnt_data_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_d     = wait_q;
    starve_d   = starve_q;

    if (arb_en) begin
      gnt_data_d = pick_d;
      we_d       = pick_d && d_we;
      addr_d     = pick_d ? d_addr : i_addr;
      wdata_d    = pick_d ? d_wdata : '0;
      if (pick_d && i_req) begin
        // Fetch waiting behind a data grant: count towards forcing it.
        if (starve_q != StarveW'(STARVE_MAX)) begin
          starve_d = starve_q + 1'b1;
        end
      end else begin
        starve_d = '0;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (arb_en) state_d = StIssue;
      end
      StIssue: begin
        state_d = StWait;
        wait_d  = CntW'(MEM_LAT - 1);
      end
      StWait: begin
        if (wait_q == '0) begin
          state_d = StResp;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      StResp: begin
        state_d = arb_en ? StIssue : StIdle;
      end
    endcase
  end

  // Output next values, derived from the next state so the registered outputs line up.
  always_comb begin
    issue_n     = (state_d == StIssue);
    mem_en_d    = issue_n;
    mem_we_d    = issue_n && we_d;
    mem_addr_d  = issue_n ? addr_d : '0;
    mem_wdata_d = issue_n ? wdata_d : '0;
    i_ready_d   = (state_d == StResp) && !gnt_data_d;
    d_ready_d   = (state_d == StResp) && gnt_data_d;

    // Read data is valid in the last WAIT cycle; stores never touch rdata.
    capture   = (state_q == StWait) && (wait_q == '0) && !we_q;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
    if (capture && !gnt_data_q) i_rdata_d = mem_rdata;
    if (capture && gnt_data_q)  d_rdata_d = mem_rdata;
  end

  // State and transaction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt_data_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_q     <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_data_q <= gnt_data_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      i_ready   <= i_ready_d;
      d_ready   <= d_ready_d;
      i_rdata   <= i_rdata_d;
      d_rdata   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: instance A (MEM_LAT=2) and instance B (MEM_LAT=1)
// sharing a word memory model. Read data goes through per-port scoreboards.

module tb_mips_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_i_req, a_i_ready, a_d_req, a_d_we, a_d_ready;
  logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  // Instance B signals
  logic        b_i_req, b_i_ready, b_d_req, b_d_we, b_d_ready;
  logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut_a (
    .clk(clk), .reset(reset),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_rdata(a_i_rdata), .i_ready(a_i_ready),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_ready(a_d_ready),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_b (
    .clk(clk), .reset(reset),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ready(b_i_ready),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  // Memory model: word array, read data valid exactly MEM_LAT cycles after mem_en.
  logic [31:0] mem [0:255];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  logic        a_p1_v = 1'b0, a_p2_v = 1'b0, b_p1_v = 1'b0;
  logic [7:0]  a_p1_i = '0, a_p2_i = '0, b_p1_i = '0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    if (a_mem_en && a_mem_we) mem[a_mem_addr[9:2]] <= a_mem_wdata;
    a_p1_v <= a_mem_en;
    a_p1_i <= a_mem_addr[9:2];
    a_p2_v <= a_p1_v;
    a_p2_i <= a_p1_i;
    b_p1_v <= b_mem_en;
    b_p1_i <= b_mem_addr[9:2];
  end

  assign a_mem_rdata = a_p2_v ? mem[a_p2_i] : 32'hBAD0BAD0;
  assign b_mem_rdata = b_p1_v ? mem[b_p1_i] : 32'hBAD0BAD0;

  int n_vec = 0;
  int n_err = 0;
  bit sb_on = 1'b0;
  logic [31:0] iq_a[$], dq_a[$], iq_b[$], dq_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [31:0] act, inout logic [31:0] q[$]);
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got unexpected ready (rdata %h), want no ready", name, act);
    end else begin
      check(name, act, q.pop_front());
    end
  endtask

  task automatic mon_step();
    if (a_i_ready && a_d_ready) begin
      n_vec++; n_err++;
      $display("FAIL a ready exclusive: got both readies high, want at most one");
    end
    if (b_i_ready && b_d_ready) begin
      n_vec++; n_err++;
      $display("FAIL b ready exclusive: got both readies high, want at most one");
    end
    if (sb_on) begin
      if (a_i_ready) pop_check("a i_rdata", a_i_rdata, iq_a);
      if (a_d_ready) pop_check("a d_rdata", a_d_rdata, dq_a);
      if (b_i_ready) pop_check("b i_rdata", b_i_rdata, iq_b);
      if (b_d_ready) pop_check("b d_rdata", b_d_rdata, dq_b);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Window recorder: cycle offsets of mem_en / readies; drops a req after its ready.
  int          en_rel[$];
  logic [31:0] en_addr[$], en_wd[$];
  logic        en_we[$];
  int          ir_rel, dr_rel, ir_cnt, dr_cnt;

  task automatic observe(input bit use_b, input int n, input int base);
    logic en, we, ir, dr;
    logic [31:0] ad, wd;
    bit drop_i, drop_d;
    en_rel.delete(); en_addr.delete(); en_wd.delete(); en_we.delete();
    ir_rel = -1; dr_rel = -1; ir_cnt = 0; dr_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (use_b) {en, we, ad, wd, ir, dr} = {b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata,
                                             b_i_ready, b_d_ready};
      else       {en, we, ad, wd, ir, dr} = {a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata,
                                             a_i_ready, a_d_ready};
      drop_i = 1'b0; drop_d = 1'b0;
      if (en) begin
        en_rel.push_back(k + base); en_addr.push_back(ad);
        en_wd.push_back(wd); en_we.push_back(we);
      end
      if (ir) begin if (ir_rel < 0) ir_rel = k + base; ir_cnt++; drop_i = 1'b1; end
      if (dr) begin if (dr_rel < 0) dr_rel = k + base; dr_cnt++; drop_d = 1'b1; end
      @(posedge clk); #1;
      if (drop_i) begin if (use_b) b_i_req = 1'b0; else a_i_req = 1'b0; end
      if (drop_d) begin if (use_b) b_d_req = 1'b0; else a_d_req = 1'b0; end
    end
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;    // rdata expected on the port at its ready pulse
  } vec_t;

  vec_t        vt[8];
  logic [31:0] grants[$];
  logic [31:0] want;
  int          n_rdy;

  initial begin
    reset = 1'b1;
    {a_i_req, a_d_req, a_d_we, b_i_req, b_d_req, b_d_we} = '0;
    {a_i_addr, a_d_addr, a_d_wdata, b_i_addr, b_d_addr, b_d_wdata} = '0;
    fork
      forever begin @(negedge clk); mon_step(); end
    join_none

    vt[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'h2002_0001};
    vt[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0011};
    vt[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0011};
    vt[3] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF};
    vt[4] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h8C01_0000};
    vt[5] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678};
    vt[6] = '{1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_0F0F, 32'h1234_5678};
    vt[7] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hA5A5_0F0F};

    repeat (2) @(posedge clk);
    #1;
    poke(8'd1, 32'h2002_0001);
    poke(8'd2, 32'h8C01_0000);
    poke(8'd16, 32'h0000_0011);
    poke(8'd64, 32'h1234_5678);
    @(negedge clk);
    check("reset a i_rdata", a_i_rdata, 32'h0);
    check("reset a d_rdata", a_d_rdata, 32'h0);
    check("reset a mem_addr", a_mem_addr, 32'h0);
    check("reset a mem_wdata", a_mem_wdata, 32'h0);
    check("reset a ctl", 32'({a_i_ready, a_d_ready, a_mem_en, a_mem_we}), 32'h0);
    check("reset b ctl", 32'({b_i_ready, b_d_ready, b_mem_en, b_mem_we}), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb_on = 1'b1;

    // Single transactions, one at a time: mem_en at +1, ready at +MEM_LAT+2.
    for (int i = 0; i < 8; i++) begin
      if (vt[i].is_d) begin
        a_d_req = 1'b1; a_d_we = vt[i].we; a_d_addr = vt[i].addr; a_d_wdata = vt[i].wdata;
        dq_a.push_back(vt[i].exp);
      end else begin
        a_i_req = 1'b1; a_i_addr = vt[i].addr;
        iq_a.push_back(vt[i].exp);
      end
      observe(1'b0, 8, 0);
      a_d_we = 1'b0;
      check($sformatf("v%0d mem_en count", i), en_rel.size(), 1);
      if (en_rel.size() > 0) begin
        check($sformatf("v%0d mem_en cycle", i), en_rel[0], 1);
        check($sformatf("v%0d mem_addr", i), en_addr[0], vt[i].addr);
        check($sformatf("v%0d mem_we", i), 32'(en_we[0]), 32'(vt[i].we));
        if (vt[i].we) check($sformatf("v%0d mem_wdata", i), en_wd[0], vt[i].wdata);
      end
      check($sformatf("v%0d ready cycle", i), vt[i].is_d ? dr_rel : ir_rel, 4);
      check($sformatf("v%0d other ready count", i), vt[i].is_d ? ir_cnt : dr_cnt, 0);
    end

    // Simultaneous fetch and load: data first, fetch directly after the data RESP.
    poke(8'd16, 32'h0000_0011);
    a_i_req = 1'b1; a_i_addr = 32'h8;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h40;
    iq_a.push_back(32'h8C01_0000);
    dq_a.push_back(32'h0000_0011);
    observe(1'b0, 12, 0);
    check("simul en count", en_rel.size(), 2);
    if (en_rel.size() >= 2) begin
      check("simul en0 cycle", en_rel[0], 1);
      check("simul en0 addr", en_addr[0], 32'h40);
      check("simul en1 cycle", en_rel[1], 5);
      check("simul en1 addr", en_addr[1], 32'h8);
    end
    check("simul d_ready cycle", dr_rel, 4);
    check("simul i_ready cycle", ir_rel, 8);

    // Starvation: both requesting; fetch released only during data RESP cycles,
    // and held low for grants 14-15 so the counter must clear.
    sb_on = 1'b0;
    a_i_addr = 32'h8; a_d_addr = 32'h40; a_d_we = 1'b0;
    a_i_req = 1'b1; a_d_req = 1'b1;
    grants.delete();
    for (int c = 0; c < 300 && grants.size() < 20; c++) begin
      @(negedge clk);
      if (a_mem_en) grants.push_back(a_mem_addr);
      if (grants.size() >= 13 && grants.size() < 15) a_i_req = 1'b0;
      else a_i_req = !a_d_ready;
    end
    a_i_req = 1'b0; a_d_req = 1'b0;
    check("starve grant count", grants.size(), 20);
    for (int k = 0; k < 20 && k < grants.size(); k++) begin
      want = (k == 4 || k == 9 || k == 19) ? 32'h8 : 32'h40;
      check($sformatf("starve grant %0d", k), grants[k], want);
    end
    repeat (10) @(posedge clk);
    #1;

    // Reset mid-load: no ready, late read data ignored, outputs cleared.
    poke(8'd16, 32'hCAFE_F00D);
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h40;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst mem_en", 32'(a_mem_en), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1; a_d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    n_rdy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("midrst ctl", 32'({a_i_ready, a_d_ready, a_mem_en, a_mem_we}), 32'h0);
        check("midrst mem_addr", a_mem_addr, 32'h0);
        check("midrst i_rdata", a_i_rdata, 32'h0);
      end
      if (a_d_ready) n_rdy++;
    end
    check("midrst d_ready count", n_rdy, 0);
    check("midrst d_rdata", a_d_rdata, 32'h0);
    @(posedge clk); #1;

    // MEM_LAT=1: fetch at cycle 0, load raised in cycle 1 follows back-to-back.
    sb_on = 1'b1;
    b_i_req = 1'b1; b_i_addr = 32'h4;
    iq_b.push_back(32'h2002_0001);
    @(posedge clk); #1;
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h100;
    dq_b.push_back(32'hA5A5_0F0F);
    observe(1'b1, 9, 1);
    check("lat1 en count", en_rel.size(), 2);
    if (en_rel.size() >= 2) begin
      check("lat1 en0 cycle", en_rel[0], 1);
      check("lat1 en0 addr", en_addr[0], 32'h4);
      check("lat1 en1 cycle", en_rel[1], 4);
      check("lat1 en1 addr", en_addr[1], 32'h100);
    end
    check("lat1 i_ready cycle", ir_rel, 3);
    check("lat1 d_ready cycle", dr_rel, 6);

    repeat (2) @(posedge clk);
    check("scoreboard drained", iq_a.size() + dq_a.size() + iq_b.size() + dq_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
